am_inserter_multi: RTL and testbench

- Parametrised 40GBASE-R alignment-marker inserter covering NUM_LANES PCS lanes in lockstep, per IEEE 802.3-2022 82.2.7/82.2.8.
- Sits between the lane distributor (scrambled 66-bit blocks per lane) and the per-lane gearboxes.
- Inserts one marker per lane every AM_PERIOD block slots and computes the per-lane BIP3/BIP7.
- Provides valid/ready backpressure on both sides, replacing the free-running "jam next cycle" stall with a real handshake.

---
 rtl/pcs_am_pkg.sv | 28 ++
 rtl/am_lane_bip.sv | 29 ++
 rtl/am_inserter_multi.sv | 74 +++++++
 tb/tb_am_inserter_multi.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_am_pkg.sv
// Shared alignment-marker constants and helpers for the 40GBASE-R marker inserter.
package pcs_am_pkg;

    // Per PCS lane, byte order M0, M1, M2, M4, M5, M6 (M3/M7 carry BIP and ~BIP).
    localparam logic [7:0] AM_BYTES [4][6] = '{
        '{8'h90, 8'h76, 8'h47, 8'h6F, 8'h89, 8'hB8},
        '{8'hF0, 8'hC4, 8'hE6, 8'h0F, 8'h3B, 8'h19},
        '{8'hC5, 8'h65, 8'h9B, 8'h3A, 8'h9A, 8'h64},
        '{8'hA2, 8'h79, 8'h3D, 8'h5D, 8'h86, 8'hC2}
    };

    function automatic logic [7:0] bip_fold(input logic [65:0] blk);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r = r ^ blk[2 + 8*k +: 8];
        end
        r[3] = r[3] ^ blk[0];
        r[4] = r[4] ^ blk[1];
        return r;
    endfunction

    function automatic logic [65:0] am_build(input logic [1:0] lane, input logic [7:0] bip);
        return {~bip, AM_BYTES[lane][5], AM_BYTES[lane][4], AM_BYTES[lane][3],
                bip, AM_BYTES[lane][2], AM_BYTES[lane][1], AM_BYTES[lane][0], 2'b01};
    endfunction

endpackage

// File: rtl/am_lane_bip.sv
// One PCS lane: BIP accumulator and selection between marker and data for the output register.
module am_lane_bip
    import pcs_am_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        restart,
    input  logic        marker,
    input  logic [65:0] data,
    output logic [65:0] blk
);

    logic [7:0] acc;

    // The marker carries the accumulator as it stood before this load.
    assign blk = marker ? am_build(2'(LANE), acc) : data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= restart ? bip_fold(blk) : (acc ^ bip_fold(blk));
        end
    end

endmodule

// File: rtl/am_inserter_multi.sv
// Multi-lane alignment-marker inserter with valid/ready handshake on both sides.
module am_inserter_multi
    import pcs_am_pkg::*;
#(
    parameter int NUM_LANES  = 4,
    parameter int FIRST_LANE = 0,
    parameter int AM_PERIOD  = 16384
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      am_enable,
    input  logic [66*NUM_LANES-1:0]   in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [66*NUM_LANES-1:0]   out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      am_slot
);

    localparam int CW = $clog2(AM_PERIOD);

    if (NUM_LANES < 1 || NUM_LANES + FIRST_LANE > 4) begin : g_bad_lanes
        $error("am_inserter_multi: lane range exceeds PCS lanes 0..3");
    end
    if (AM_PERIOD < 4 || (AM_PERIOD & (AM_PERIOD - 1)) != 0) begin : g_bad_period
        $error("am_inserter_multi: AM_PERIOD must be a power of two >= 4");
    end

    logic [CW-1:0]            cnt;
    logic                     load;
    logic                     slot0;
    logic                     am_now;
    logic                     wr;
    logic [66*NUM_LANES-1:0]  blk_next;

    assign load     = ~out_valid | out_ready;
    assign slot0    = (cnt == '0);
    assign am_now   = slot0 & am_enable;
    assign in_ready = load & ~am_now;
    assign wr       = load & (am_now | in_valid);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        am_lane_bip #(
            .LANE (FIRST_LANE + i)
        ) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .load    (wr),
            .restart (slot0),
            .marker  (am_now),
            .data    (in_data[66*i +: 66]),
            .blk     (blk_next[66*i +: 66])
        );
    end

    // A write always advances the slot; a load with nothing to write only drains the register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            am_slot   <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            out_valid <= wr;
            am_slot   <= am_now;
            if (wr) begin
                out_data <= blk_next;
                cnt      <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_am_inserter_multi.sv
// Self-checking bench for am_inserter_multi: directed table, corner sequences and a random scoreboard.
module tb_am_inserter_multi;

    localparam int P = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         am_enable = 1'b1;
    logic [263:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [263:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         am_slot;

    logic [131:0] in_data2 = '0;
    logic         in_ready2;
    logic [131:0] out_data2;
    logic         out_valid2;
    logic         am_slot2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    am_inserter_multi #(.NUM_LANES(4), .FIRST_LANE(0), .AM_PERIOD(P)) dut (
        .clk(clk), .reset_n(reset_n), .am_enable(am_enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .am_slot(am_slot)
    );

    am_inserter_multi #(.NUM_LANES(2), .FIRST_LANE(2), .AM_PERIOD(P)) dut2 (
        .clk(clk), .reset_n(reset_n), .am_enable(1'b1),
        .in_data(in_data2), .in_valid(1'b1), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(1'b1),
        .am_slot(am_slot2)
    );

    logic [23:0] ref_hi [4] = '{24'hB8896F, 24'h193B0F, 24'h649A3A, 24'hC2865D};
    logic [23:0] ref_lo [4] = '{24'h477690, 24'hE6C4F0, 24'h9B65C5, 24'h3D79A2};

    function automatic logic [7:0] ref_fold(input logic [65:0] b);
        logic [7:0] r;
        r = '0;
        for (int j = 2; j < 66; j++) r[(j - 2) % 8] = r[(j - 2) % 8] ^ b[j];
        r[3] = r[3] ^ b[0];
        r[4] = r[4] ^ b[1];
        return r;
    endfunction

    function automatic logic [65:0] ref_am(input int lane, input logic [7:0] bip);
        return {~bip, ref_hi[lane], bip, ref_lo[lane], 2'b01};
    endfunction

    function automatic logic [263:0] rand_blk();
        logic [287:0] w;
        for (int i = 0; i < 9; i++) w[32*i +: 32] = $urandom;
        return w[263:0];
    endfunction

    task automatic check(input string nm, input logic [263:0] act, input logic [263:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic iv;
        logic ordy;
        logic exp_rdy;
        logic exp_ov;
        logic exp_am;
    } vec_t;

    vec_t vt [18];

    logic [263:0] mq [$];
    logic [7:0]   macc [4];
    logic [263:0] exp_blk;
    logic [263:0] held;
    logic [263:0] prev_in;
    logic [65:0]  first_m;
    logic         hold_pend;
    logic         exp_mk;
    int           slot_s;

    initial begin
        for (int k = 0; k < 18; k++)
            vt[k] = '{1'b1, 1'b1, (k % P) != 0, k > 0, (k % P) == 1};

        // reset state
        #1;
        check("rst_out_valid", 264'(out_valid), 264'(0));
        check("rst_out_data", out_data, '0);
        check("rst_am_slot", 264'(am_slot), 264'(0));

        // directed run: zero data, continuous flow
        am_enable = 1'b1;
        in_data = '0;
        in_data2 = '0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            in_valid = vt[k].iv;
            out_ready = vt[k].ordy;
            #1;
            check($sformatf("tbl_in_ready[%0d]", k), 264'(in_ready), 264'(vt[k].exp_rdy));
            check($sformatf("tbl_out_valid[%0d]", k), 264'(out_valid), 264'(vt[k].exp_ov));
            check($sformatf("tbl_am_slot[%0d]", k), 264'(am_slot), 264'(vt[k].exp_am));
            if (k == 1) begin
                check("first_am_lane0", 264'(out_data[65:0]),
                      264'({8'hFF, 24'hB8896F, 8'h00, 24'h477690, 2'b01}));
                check("first_am_lane3", 264'(out_data[263:198]),
                      264'({8'hFF, 24'hC2865D, 8'h00, 24'h3D79A2, 2'b01}));
                check("dut2_am_lane0", 264'(out_data2[65:0]), 264'(ref_am(2, 8'h00)));
                check("dut2_am_lane1", 264'(out_data2[131:66]), 264'(ref_am(3, 8'h00)));
            end
            if (k == 9) begin
                for (int l = 0; l < 4; l++) begin
                    first_m = ref_am(l, 8'h00);
                    check($sformatf("second_am_lane%0d", l), 264'(out_data[66*l +: 66]),
                          264'(ref_am(l, ref_fold(first_m))));
                end
            end
            @(negedge clk);
        end

        // reset in the middle of a period with random data flowing
        in_data = rand_blk();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_data = rand_blk();
            in_data2 = in_data[131:0];
            @(negedge clk);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", 264'(out_valid), 264'(0));
        check("async_rst_out_data", out_data, '0);
        check("async_rst_dut2_valid", 264'(out_valid2), 264'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_am_slot", 264'(am_slot), 264'(1));
        for (int l = 0; l < 4; l++)
            check($sformatf("post_rst_am_lane%0d", l), 264'(out_data[66*l +: 66]), 264'(ref_am(l, 8'h00)));
        check("post_rst_dut2_lane0", 264'(out_data2[65:0]), 264'(ref_am(2, 8'h00)));

        // markers disabled: straight one-cycle pipe
        am_enable = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        do_reset();
        prev_in = '0;
        for (int k = 0; k < 24; k++) begin
            prev_in = in_data;
            in_data = rand_blk();
            #1;
            check($sformatf("noam_in_ready[%0d]", k), 264'(in_ready), 264'(1));
            if (k > 0) begin
                check($sformatf("noam_data[%0d]", k), out_data, prev_in);
                check($sformatf("noam_am_slot[%0d]", k), 264'(am_slot), 264'(0));
            end
            @(negedge clk);
        end

        // random handshake against a stream scoreboard
        am_enable = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        do_reset();
        mq.delete();
        for (int l = 0; l < 4; l++) macc[l] = 8'h00;
        slot_s = 0;
        hold_pend = 1'b0;
        held = '0;
        for (int c = 0; c < 2000; c++) begin
            if (hold_pend) begin
                check("hold_valid", 264'(out_valid), 264'(1));
                check("hold_data", out_data, held);
            end
            if (c < 1960) begin
                in_valid = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            in_data = rand_blk();
            #1;
            if (in_valid && in_ready) mq.push_back(in_data);
            if (out_valid && out_ready) begin
                exp_mk = (slot_s % P) == 0;
                if (exp_mk) begin
                    for (int l = 0; l < 4; l++) begin
                        exp_blk[66*l +: 66] = ref_am(l, macc[l]);
                        macc[l] = ref_fold(exp_blk[66*l +: 66]);
                    end
                end else if (mq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_underflow actual=output_block required=no_pending_input");
                    exp_blk = out_data;
                end else begin
                    exp_blk = mq.pop_front();
                    for (int l = 0; l < 4; l++) macc[l] = macc[l] ^ ref_fold(exp_blk[66*l +: 66]);
                end
                check($sformatf("rnd_block[%0d]", slot_s), out_data, exp_blk);
                check($sformatf("rnd_am_slot[%0d]", slot_s), 264'(am_slot), 264'(exp_mk));
                slot_s++;
            end
            hold_pend = out_valid && !out_ready;
            held = out_data;
            @(negedge clk);
        end
        check("rnd_pending_inputs", 264'(mq.size()), 264'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
